// File: rtl/aes_round_ctrl.sv
// Round sequencer for an iterative AES datapath: key-expansion trigger, load, rounds, result hold.
// Optional inverse cipher (mode/inv ports, reversed round-key order) enabled by defining AES_DECRYPT_EN.
module aes_round_ctrl #(
    parameter int unsigned NUM_ROUNDS = 10,
    parameter int unsigned RND_BITS   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                key_new,
    output logic                kexp_start,
    input  logic                kexp_done,
    output logic                ld_state,
    output logic                rnd_en,
    output logic                mix_bypass,
    output logic [RND_BITS-1:0] rk_idx,
    output logic [RND_BITS-1:0] round_cnt,
    output logic                out_valid,
    input  logic                out_ready
`ifdef AES_DECRYPT_EN
    ,
    input  logic                mode,
    output logic                inv
`endif
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        KEXP  = 3'd1,
        LOAD  = 3'd2,
        ROUND = 3'd3,
        DONE  = 3'd4
    } state_e;

    localparam logic [RND_BITS-1:0] LAST_RND = RND_BITS'(NUM_ROUNDS);
    localparam logic [RND_BITS-1:0] ONE_RND  = RND_BITS'(1);

    state_e              state_q;
    logic [RND_BITS-1:0] rnd_q;
    logic [RND_BITS-1:0] rnd_d;
    logic [RND_BITS-1:0] rk_idx_q;
    logic                in_ready_q;
    logic                kexp_start_q;
    logic                ld_state_q;
    logic                rnd_en_q;
    logic                mix_bypass_q;
    logic                out_valid_q;
    logic                dec_q;
    logic                dec_in;

`ifdef AES_DECRYPT_EN
    assign dec_in = mode;
    // Inverse select is only meaningful while the datapath owns a block.
    assign inv    = dec_q & (ld_state_q | rnd_en_q | out_valid_q);
`else
    assign dec_in = 1'b0;
`endif

    // Decryption walks the key schedule backwards so the final round uses key 0.
    function automatic logic [RND_BITS-1:0] key_idx(input logic dec,
                                                    input logic [RND_BITS-1:0] r);
        return dec ? (LAST_RND - r) : r;
    endfunction

    assign rnd_d = rnd_q + ONE_RND;

    // Single-process FSM; every output register is rebuilt each cycle for the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rnd_q        <= '0;
            rk_idx_q     <= '0;
            in_ready_q   <= 1'b1;
            kexp_start_q <= 1'b0;
            ld_state_q   <= 1'b0;
            rnd_en_q     <= 1'b0;
            mix_bypass_q <= 1'b0;
            out_valid_q  <= 1'b0;
            dec_q        <= 1'b0;
        end else begin
            rk_idx_q     <= '0;
            in_ready_q   <= 1'b0;
            kexp_start_q <= 1'b0;
            ld_state_q   <= 1'b0;
            rnd_en_q     <= 1'b0;
            mix_bypass_q <= 1'b0;
            out_valid_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        dec_q <= dec_in;
                        if (key_new) begin
                            state_q      <= KEXP;
                            kexp_start_q <= 1'b1;
                        end else begin
                            state_q    <= LOAD;
                            ld_state_q <= 1'b1;
                            rk_idx_q   <= key_idx(dec_in, '0);
                        end
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                KEXP: begin
                    if (kexp_done) begin
                        state_q    <= LOAD;
                        ld_state_q <= 1'b1;
                        rk_idx_q   <= key_idx(dec_q, '0);
                    end
                end
                LOAD: begin
                    state_q      <= ROUND;
                    rnd_q        <= ONE_RND;
                    rnd_en_q     <= 1'b1;
                    rk_idx_q     <= key_idx(dec_q, ONE_RND);
                    mix_bypass_q <= (ONE_RND == LAST_RND);
                end
                ROUND: begin
                    if (rnd_q == LAST_RND) begin
                        state_q     <= DONE;
                        rnd_q       <= '0;
                        out_valid_q <= 1'b1;
                    end else begin
                        rnd_q        <= rnd_d;
                        rnd_en_q     <= 1'b1;
                        rk_idx_q     <= key_idx(dec_q, rnd_d);
                        mix_bypass_q <= (rnd_d == LAST_RND);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q    <= IDLE;
                        in_ready_q <= 1'b1;
                    end else begin
                        out_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    rnd_q      <= '0;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign kexp_start = kexp_start_q;
    assign ld_state   = ld_state_q;
    assign rnd_en     = rnd_en_q;
    assign mix_bypass = mix_bypass_q;
    assign rk_idx     = rk_idx_q;
    assign round_cnt  = rnd_q;
    assign out_valid  = out_valid_q;

endmodule
